// File: rtl/bram_stream_reader.sv
// Streams a burst of 32-bit words from a block RAM read port into a valid/ready stream.
// Optional macro BRAM_READER_LOOP_EN adds a loop input for repeating passes until stopped.
module bram_stream_reader #(
   parameter int MEM_ADDR_WIDTH = 13
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      stop,
   input  logic [MEM_ADDR_WIDTH-1:0] baseAddr,
   input  logic [MEM_ADDR_WIDTH:0]   length,
`ifdef BRAM_READER_LOOP_EN
   input  logic                      loop,
`endif
   output logic [MEM_ADDR_WIDTH-1:0] memAddr,
   output logic                      memRdEn,
   input  logic [31:0]               memData,
   output logic [31:0]               outData,
   output logic                      outValid,
   input  logic                      outReady,
   output logic                      outLast,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateT;

   localparam logic [MEM_ADDR_WIDTH-1:0] ONE_ADDR = 1;
   localparam logic [MEM_ADDR_WIDTH:0]   ONE_LEN  = 1;

   stateT                     stateReg;
   logic [MEM_ADDR_WIDTH-1:0] addrReg;
   logic [MEM_ADDR_WIDTH:0]   remainReg;
   logic                      inFlightReg;
   logic                      inFlightLastReg;
   logic                      doneReg;
   logic [31:0]               fifoData [2];
   logic                      fifoLast [2];
   logic                      rdPtrReg;
   logic                      wrPtrReg;
   logic [1:0]                countReg;

   logic       fifoHasData;
   logic       pop;
   logic       push;
   logic       fifoPop;
   logic       lastIssue;
   logic       accept;
   logic       loopActive;
   logic [2:0] occ;

   // The head of the stream is the oldest FIFO entry, or the word landing from RAM this cycle.
   assign fifoHasData = (countReg != 2'd0);
   assign outValid    = fifoHasData | inFlightReg;
   assign outData     = fifoHasData ? fifoData[rdPtrReg] : (inFlightReg ? memData : 32'd0);
   assign outLast     = fifoHasData ? fifoLast[rdPtrReg] : (inFlightReg & inFlightLastReg);
   assign pop         = outValid & outReady;
   assign push        = inFlightReg & ~(pop & ~fifoHasData);
   assign fifoPop     = pop & fifoHasData;

   assign occ       = {1'b0, countReg} + {2'b00, inFlightReg} - {2'b00, pop};
   assign memRdEn   = (stateReg == RUN) && (occ < 3'd2);
   assign lastIssue = memRdEn && (remainReg == ONE_LEN);
   assign accept    = (stateReg == IDLE) && start && !stop;

   assign memAddr = addrReg;
   assign busy    = (stateReg != IDLE);
   assign done    = doneReg;

`ifdef BRAM_READER_LOOP_EN
   logic                      loopReg;
   logic [MEM_ADDR_WIDTH-1:0] baseReg;
   logic [MEM_ADDR_WIDTH:0]   lengthReg;

   always_ff @(posedge clk) begin
      if (rst) begin
         loopReg   <= 1'b0;
         baseReg   <= '0;
         lengthReg <= '0;
      end else if (accept) begin
         loopReg   <= loop;
         baseReg   <= baseAddr;
         lengthReg <= length;
      end
   end

   assign loopActive = loopReg;
`else
   assign loopActive = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         fifoData[wrPtrReg] <= memData;
         fifoLast[wrPtrReg] <= inFlightLastReg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg        <= IDLE;
         addrReg         <= '0;
         remainReg       <= '0;
         inFlightReg     <= 1'b0;
         inFlightLastReg <= 1'b0;
         doneReg         <= 1'b0;
         rdPtrReg        <= 1'b0;
         wrPtrReg        <= 1'b0;
         countReg        <= 2'd0;
      end else begin
         doneReg         <= 1'b0;
         inFlightReg     <= memRdEn;
         inFlightLastReg <= lastIssue;

         if (memRdEn) begin
            addrReg   <= addrReg + ONE_ADDR;
            remainReg <= remainReg - ONE_LEN;
`ifdef BRAM_READER_LOOP_EN
            if (lastIssue && loopReg) begin
               addrReg   <= baseReg;
               remainReg <= lengthReg;
            end
`endif
         end

         if (push)    wrPtrReg <= ~wrPtrReg;
         if (fifoPop) rdPtrReg <= ~rdPtrReg;
         case ({push, fifoPop})
            2'b10:   countReg <= countReg + 2'd1;
            2'b01:   countReg <= countReg - 2'd1;
            default: countReg <= countReg;
         endcase

         case (stateReg)
            IDLE: begin
               if (accept) begin
                  if (length == '0) begin
                     doneReg <= 1'b1;
                  end else begin
                     stateReg  <= RUN;
                     addrReg   <= baseAddr;
                     remainReg <= length;
                  end
               end
            end
            RUN, DRAIN: begin
               if (stop) begin
                  // Abort: everything buffered or still arriving from RAM is dropped.
                  stateReg    <= IDLE;
                  inFlightReg <= 1'b0;
                  rdPtrReg    <= 1'b0;
                  wrPtrReg    <= 1'b0;
                  countReg    <= 2'd0;
               end else if (stateReg == RUN) begin
                  if (lastIssue && !loopActive) stateReg <= DRAIN;
               end else if (pop && outLast) begin
                  stateReg <= IDLE;
                  doneReg  <= 1'b1;
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: word-index stream model plus directed literal checks.
module tb_bram_stream_reader;

   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst, start, stop, outReady, loopIn;
   logic [AW-1:0] baseAddr;
   logic [AW:0]   length;
   logic [AW-1:0] memAddr;
   logic          memRdEn;
   logic [31:0]   memData;
   logic [31:0]   outData;
   logic          outValid, outLast, busy, done;

   always #5 clk = ~clk;

   bram_stream_reader #(.MEM_ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .baseAddr (baseAddr),
      .length   (length),
`ifdef BRAM_READER_LOOP_EN
      .loop     (loopIn),
`endif
      .memAddr  (memAddr),
      .memRdEn  (memRdEn),
      .memData  (memData),
      .outData  (outData),
      .outValid (outValid),
      .outReady (outReady),
      .outLast  (outLast),
      .busy     (busy),
      .done     (done)
   );

   function automatic logic [31:0] ramWord(input logic [AW-1:0] a);
      return 32'hCAFE0000 | {19'd0, a};
   endfunction

   // RAM with one-cycle read latency; junk on cycles with no read.
   always @(posedge clk) memData <= memRdEn ? ramWord(memAddr) : 32'hDEADBEEF;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Stream model: word k of a burst is RAM[base + (k mod len)], last when k mod len == len-1.
   logic          checkEn = 1'b0;
   logic          mBusy = 1'b0;
   logic          doneDue = 1'b0;
   logic          mLoop = 1'b0;
   logic [AW-1:0] mBase = '0;
   int            mLen = 1;
   int            j = 0;
   int            k = 0;
   int            xferTotal = 0;
   logic [AW-1:0] issuedQ [$];

   always @(negedge clk) begin
      logic [AW-1:0] expAddr;
      int            kk;
      logic          lastXfer;
      logic          nextDone;
      if (checkEn) begin
         lastXfer = 1'b0;
         chk("busy", busy, mBusy);
         chk("done", done, doneDue);
         if (!mBusy) begin
            chk("idleOutValid", outValid, 1'b0);
            chk("idleMemRdEn", memRdEn, 1'b0);
         end else begin
            if (memRdEn) begin
               chk("readAllowed", (mLoop || j < mLen), 1'b1);
               kk = j % mLen;
               expAddr = mBase + kk[AW-1:0];
               chk("memAddr", memAddr, expAddr);
               issuedQ.push_back(memAddr);
               j++;
            end
            if (outValid) begin
               kk = k % mLen;
               expAddr = mBase + kk[AW-1:0];
               chk("outData", outData, ramWord(expAddr));
               chk("outLast", outLast, (kk == mLen - 1));
               if (outReady) begin
                  $display("[TB] xfer %0d data=%h last=%0b", xferTotal, outData, outLast);
                  lastXfer = (kk == mLen - 1);
                  k++;
                  xferTotal++;
               end
            end
            chk("outstanding", (j - k <= 2), 1'b1);
         end

         nextDone = 1'b0;
         if (rst) begin
            mBusy = 1'b0;
         end else if (mBusy) begin
            if (stop) mBusy = 1'b0;
            else if (lastXfer && !mLoop) begin
               mBusy = 1'b0;
               nextDone = 1'b1;
            end
         end else if (start && !stop) begin
            if (length == '0) nextDone = 1'b1;
            else begin
               mBusy = 1'b1;
               mBase = baseAddr;
               mLen  = int'(length);
               mLoop = loopIn;
               j = 0;
               k = 0;
            end
         end
         doneDue = nextDone;
      end
   end

   task automatic startBurst(input logic [AW-1:0] b, input logic [AW:0] len, input logic lp);
      baseAddr = b;
      length   = len;
      loopIn   = lp;
      start    = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, busy, 1'b0);
   endtask

   initial begin
      logic [31:0]   expA [4];
      logic [AW-1:0] expC [4];
      int            x0;
      int            n;
      expA = '{32'hCAFE0010, 32'hCAFE0011, 32'hCAFE0012, 32'hCAFE0013};
      expC = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};

      rst = 1'b1; start = 1'b0; stop = 1'b0; outReady = 1'b1; loopIn = 1'b0;
      baseAddr = '0; length = '0;
      repeat (2) @(posedge clk);
      #1 checkEn = 1'b1;
      @(negedge clk);
      chk("rst.memAddr", memAddr, 13'h0);
      chk("rst.outData", outData, 32'h0);
      chk("rst.outValid", outValid, 1'b0);
      chk("rst.outLast", outLast, 1'b0);
      chk("rst.memRdEn", memRdEn, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;

      // Basic burst: latency 2, one word per cycle, done after the last word.
      startBurst(13'h010, 4, 1'b0);
      @(negedge clk);
      chk("A.rdEn", memRdEn, 1'b1);
      chk("A.addr", memAddr, 13'h010);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("A.valid", outValid, 1'b1);
         chk("A.data", outData, expA[i]);
         chk("A.last", outLast, (i == 3));
      end
      @(negedge clk);
      chk("A.done", done, 1'b1);
      chk("A.busy", busy, 1'b0);
      @(posedge clk); #1;

      // Back-pressure with ready toggling every cycle.
      x0 = xferTotal;
      startBurst(13'h100, 8, 1'b0);
      n = 0;
      while (busy && n < 80) begin
         outReady = ~outReady;
         @(posedge clk); #1;
         n++;
      end
      outReady = 1'b1;
      chk("B.idle", busy, 1'b0);
      chk("B.xfers", xferTotal - x0, 8);
      @(posedge clk); #1;

      // Address wrap at the top of the RAM.
      issuedQ.delete();
      startBurst(13'h1FFE, 4, 1'b0);
      waitIdle("C.idle", 40);
      chk("C.reads", issuedQ.size(), 4);
      for (int i = 0; i < 4 && i < issuedQ.size(); i++) chk("C.addr", issuedQ[i], expC[i]);
      @(posedge clk); #1;

      // Stop after three words (start raised alongside must not restart).
      x0 = xferTotal;
      startBurst(13'h040, 10, 1'b0);
      n = 0;
      while (xferTotal - x0 < 3 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      stop = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("D.outValid", outValid, 1'b0);
      chk("D.busy", busy, 1'b0);
      chk("D.partial", (xferTotal - x0 < 10), 1'b1);
      repeat (3) @(posedge clk);
      #1 x0 = xferTotal;
      startBurst(13'h020, 2, 1'b0);
      waitIdle("D.restartIdle", 40);
      chk("D.restartXfers", xferTotal - x0, 2);
      @(posedge clk); #1;

      // Reset mid-burst.
      startBurst(13'h080, 10, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("E.outValid", outValid, 1'b0);
      chk("E.busy", busy, 1'b0);
      chk("E.memAddr", memAddr, 13'h0);
      @(posedge clk); #1 x0 = xferTotal;
      startBurst(13'h090, 3, 1'b0);
      waitIdle("E.restartIdle", 40);
      chk("E.restartXfers", xferTotal - x0, 3);
      @(posedge clk); #1;

      // Zero length: done next cycle, nothing streamed.
      x0 = xferTotal;
      startBurst(13'h055, 0, 1'b0);
      @(negedge clk);
      chk("F.done", done, 1'b1);
      chk("F.busy", busy, 1'b0);
      @(negedge clk);
      chk("F.doneOnce", done, 1'b0);
      chk("F.xfers", xferTotal - x0, 0);
      @(posedge clk); #1;

      // Start and stop together while idle: stop wins.
      baseAddr = 13'h066; length = 5; start = 1'b1; stop = 1'b1;
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("G.busy", busy, 1'b0);
      @(posedge clk); #1;

      // Start while busy is ignored.
      x0 = xferTotal;
      startBurst(13'h200, 6, 1'b0);
      startBurst(13'h300, 2, 1'b0);
      waitIdle("H.idle", 40);
      chk("H.xfers", xferTotal - x0, 6);
      @(posedge clk); #1;

`ifdef BRAM_READER_LOOP_EN
      // Looping pass of three words until stopped.
      x0 = xferTotal;
      startBurst(13'h030, 3, 1'b1);
      repeat (14) @(posedge clk);
      #1 chk("I.xfers", (xferTotal - x0 >= 9), 1'b1);
      chk("I.busy", busy, 1'b1);
      stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      loopIn = 1'b0;
      @(negedge clk);
      chk("I.stopBusy", busy, 1'b0);
      chk("I.stopValid", outValid, 1'b0);
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
